// File: rtl/prio_dispatch_dec.sv
// prio_dispatch_dec: turns an encoded index into a held one-hot dispatch line.
// Latency: 1 cycle from accept to the line being driven; held until ack or timeout, then a dead gap.
// Backpressure: in_ready is high only while idle; codes offered during drive/gap are ignored.
// Ports: clk/rst (async active-high), in_code/in_valid/in_ready upstream handshake,
//        out_onehot/out_valid/out_ack downstream line, last_code, sticky timeout_err with err_clr.
module prio_dispatch_dec #(
  parameter int CODE_W     = 3,
  parameter int TIMEOUT    = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CODE_W-1:0]      in_code,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [(1<<CODE_W)-1:0] out_onehot,
  output logic                   out_valid,
  input  logic                   out_ack,
  output logic [CODE_W-1:0]      last_code,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  localparam int OUT_W = 1 << CODE_W;
  localparam int MAX_V = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CNT_W = ($clog2(MAX_V + 1) < 1) ? 1 : $clog2(MAX_V + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   onehot_q, onehot_d;
  logic [CODE_W-1:0]  last_code_q, last_code_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               release_line;
  logic               timed_out;

  assign in_ready    = (state_q == IDLE);
  assign out_onehot  = onehot_q;
  assign out_valid   = |onehot_q;
  assign last_code   = last_code_q;
  assign timeout_err = err_q;

  // Timeout only matters when no ack arrives on the same edge; ack takes priority.
  assign timed_out    = (TIMEOUT > 0) && (hold_cnt_q == HOLD_LAST) && !out_ack;
  assign release_line = out_ack || timed_out;

  always_comb begin
    state_d     = state_q;
    onehot_d    = onehot_q;
    last_code_d = last_code_q;
    err_d       = err_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;

    // Clear first so a simultaneous timeout below overrides it.
    if (err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d     = DRIVE;
          onehot_d    = OUT_W'(1) << in_code;
          last_code_d = in_code;
          hold_cnt_d  = '0;
        end
      end

      DRIVE: begin
        if (release_line) begin
          onehot_d   = '0;
          hold_cnt_d = '0;
          if (timed_out) begin
            err_d = 1'b1;
          end
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (hold_cnt_q != CNT_MAX) begin
          // Saturates only in the no-timeout configuration, where the hold is unbounded.
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      onehot_q    <= '0;
      last_code_q <= '0;
      err_q       <= 1'b0;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      onehot_q    <= onehot_d;
      last_code_q <= last_code_d;
      err_q       <= err_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_prio_dispatch_dec.sv
// tb_prio_dispatch_dec: directed bench for prio_dispatch_dec with default parameters.
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: bench waits (bounded) for in_ready before offering each code.
module tb_prio_dispatch_dec;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_code = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_onehot;
  logic       out_valid;
  logic       out_ack = 1'b0;
  logic [2:0] last_code;
  logic       timeout_err;
  logic       err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  prio_dispatch_dec #(.CODE_W(3), .TIMEOUT(16), .GAP_CYCLES(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_code     (in_code),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_onehot  (out_onehot),
    .out_valid   (out_valid),
    .out_ack     (out_ack),
    .last_code   (last_code),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then offers one code for a single edge.
  task automatic send(input logic [2:0] code);
    int budget = 50;
    while (!in_ready && budget > 0) begin
      tick();
      budget--;
    end
    n_checks++;
    if (!in_ready) begin
      n_fail++;
      $display("FAIL send_ready_wait: in_ready=%0b required 1 within budget", in_ready);
    end
    in_code  = code;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (out_onehot !== 8'h00) begin n_fail++; $display("FAIL rst_onehot: got %h want 00", out_onehot); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", timeout_err); end
    n_checks++; if (last_code !== 3'd0) begin n_fail++; $display("FAIL rst_last_code: got %0d want 0", last_code); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b1 || out_onehot !== 8'h00) begin n_fail++; $display("FAIL idle_after_rst: ready=%b onehot=%h want 1/00", in_ready, out_onehot); end
  endtask

  task automatic test_single();
    send(3'd5);
    n_checks++; if (out_onehot !== 8'h20) begin n_fail++; $display("FAIL single_onehot: got %h want 20", out_onehot); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_checks++; if (last_code !== 3'd5) begin n_fail++; $display("FAIL single_last_code: got %0d want 5", last_code); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_in_ready: got %b want 0", in_ready); end
    tick();
    tick();
    n_checks++; if (out_onehot !== 8'h20) begin n_fail++; $display("FAIL single_hold: got %h want 20", out_onehot); end
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    n_checks++; if (out_onehot !== 8'h00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_release: onehot=%h valid=%b want 00/0", out_onehot, out_valid); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_gap_ready: got %b want 0", in_ready); end
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_after_gap: got %b want 1", in_ready); end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_line;
    for (int c = 0; c < 8; c++) begin
      exp_line = 8'h01 << c;
      in_code  = 3'(c);
      in_valid = 1'b1;
      tick();
      n_checks++; if (out_onehot !== exp_line || $countones(out_onehot) != 1) begin n_fail++; $display("FAIL sweep_line[%0d]: got %h want %h", c, out_onehot, exp_line); end
      // Keep in_valid high with a different code through drive and gap.
      in_code = 3'(c) ^ 3'd7;
      out_ack = 1'b1;
      tick();
      out_ack = 1'b0;
      n_checks++; if (out_onehot !== 8'h00 || last_code !== 3'(c)) begin n_fail++; $display("FAIL sweep_release[%0d]: onehot=%h last=%0d want 00/%0d", c, out_onehot, last_code, c); end
      tick();
      n_checks++; if (out_onehot !== 8'h00 || in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_gap_ignore[%0d]: onehot=%h ready=%b want 00/1", c, out_onehot, in_ready); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_timeout();
    send(3'd3);
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (out_onehot !== 8'h08) begin n_fail++; $display("FAIL timeout_hold[%0d]: got %h want 08", i, out_onehot); end
      n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_early_err[%0d]: got %b want 0", i, timeout_err); end
      tick();
    end
    n_checks++; if (out_onehot !== 8'h00) begin n_fail++; $display("FAIL timeout_drop: got %h want 00", out_onehot); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %b want 1", timeout_err); end
    send(3'd1);
    n_checks++; if (out_onehot !== 8'h02) begin n_fail++; $display("FAIL timeout_next_code: got %h want 02", out_onehot); end
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    tick();
  endtask

  task automatic test_same_edge();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b want 0", timeout_err); end
    // Ack on the final permitted hold cycle.
    send(3'd2);
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if (out_onehot !== 8'h04) begin n_fail++; $display("FAIL ack_to_hold: got %h want 04", out_onehot); end
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    n_checks++; if (out_onehot !== 8'h00 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL ack_wins: onehot=%h err=%b want 00/0", out_onehot, timeout_err); end
    // err_clr on the same edge as a new timeout.
    send(3'd4);
    for (int i = 0; i < 15; i++) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++; if (out_onehot !== 8'h00 || timeout_err !== 1'b1) begin n_fail++; $display("FAIL set_wins: onehot=%h err=%b want 00/1", out_onehot, timeout_err); end
    tick();
    // out_ack outside DRIVE must not disturb anything.
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_onehot !== 8'h00) begin n_fail++; $display("FAIL idle_ack_ignored: ready=%b onehot=%h want 1/00", in_ready, out_onehot); end
  endtask

  task automatic test_reset_mid_drive();
    send(3'd7);
    n_checks++; if (out_onehot !== 8'h80) begin n_fail++; $display("FAIL mid_drive_line: got %h want 80", out_onehot); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_onehot !== 8'h00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_drop: onehot=%h valid=%b want 00/0", out_onehot, out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_ready: got %b want 1", in_ready); end
    n_checks++; if (timeout_err !== 1'b0 || last_code !== 3'd0) begin n_fail++; $display("FAIL async_rst_state: err=%b last=%0d want 0/0", timeout_err, last_code); end
    #3;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (out_onehot !== 8'h00 || in_ready !== 1'b1) begin n_fail++; $display("FAIL no_replay[%0d]: onehot=%h ready=%b want 00/1", i, out_onehot, in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_timeout();
    test_same_edge();
    test_reset_mid_drive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
